// File: rtl/lookup_mult_arbiter.sv
// lookup_mult_arbiter
//
// Shares one external 8x8 quarter-square lookup multiplier between NUM_REQ
// requesters. A round-robin arbiter grants one request at a time. The
// operands are held on mul_a/mul_b while the multiplier works, and the
// product is returned with the owner's index on a valid/ready channel.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester request valid
//   req_a      packed multiplicands, requester i at [8i+7:8i]
//   req_b      packed multiplier operands, same packing
//   req_ready  per-requester accept, one-hot or zero, only in IDLE
//   mul_a      operand A to the shared multiplier
//   mul_b      operand B to the shared multiplier
//   mul_p      product from the shared multiplier
//   rsp_valid  response valid
//   rsp_ready  response accepted by the consumer
//   rsp_p      product a*b, taken verbatim from mul_p
//   rsp_id     index of the requester that owns rsp_p
//   busy       high in any state other than IDLE
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation in flight; grant the round-robin winner
// EXEC  | operands on mul_a/mul_b; count down the multiplier latency
// RESP  | product presented on rsp_*; wait for rsp_ready

module lookup_mult_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int MUL_LATENCY = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [8*NUM_REQ-1:0]   req_a,
  input  logic [8*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [7:0]             mul_a,
  output logic [7:0]             mul_b,
  input  logic [15:0]            mul_p,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [15:0]            rsp_p,
  output logic [ID_WIDTH-1:0]    rsp_id,
  output logic                   busy
);

  localparam int CNT_W = 3;
  localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [7:0]          mul_a_q, mul_a_d;
  logic [7:0]          mul_b_q, mul_b_d;
  logic [15:0]         rsp_p_q, rsp_p_d;
  logic [ID_WIDTH-1:0] rsp_id_q, rsp_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                busy_q, busy_d;

  // Round-robin winner search
  logic [NUM_REQ-1:0]  rot;
  logic [ID_WIDTH-1:0] off;
  logic                found;
  logic [ID_WIDTH:0]   sum;
  logic [ID_WIDTH-1:0] winner;
  logic [ID_WIDTH:0]   nxt;
  logic [7:0]          sel_a;
  logic [7:0]          sel_b;

  always_comb begin
    // Rotate so bit 0 is the requester at ptr; the lowest set bit of the
    // rotated vector is then the offset of the winner from ptr.
    rot   = NUM_REQ'({req_valid, req_valid} >> ptr_q);
    found = 1'b0;
    off   = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        found = 1'b1;
        off   = ID_WIDTH'(j);
      end
    end

    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= NUM_REQ_W) begin
      sum = sum - NUM_REQ_W;
    end
    winner = sum[ID_WIDTH-1:0];

    nxt = {1'b0, winner} + (ID_WIDTH+1)'(1);
    if (nxt >= NUM_REQ_W) begin
      nxt = '0;
    end

    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (winner == ID_WIDTH'(i)) begin
        sel_a = req_a[8*i +: 8];
        sel_b = req_b[8*i +: 8];
      end
    end
  end

  // The grant is combinational so the requester sees ready in the same
  // cycle the operands are captured.
  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found) begin
      req_ready = NUM_REQ'(1) << winner;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_p_d     = rsp_p_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;

    case (state_q)
      IDLE: begin
        if (found) begin
          mul_a_d  = sel_a;
          mul_b_d  = sel_b;
          rsp_id_d = winner;
          cnt_d    = CNT_W'(MUL_LATENCY);
          ptr_d    = nxt[ID_WIDTH-1:0];
          state_d  = EXEC;
          busy_d   = 1'b1;
        end
      end

      EXEC: begin
        if (cnt_q == '0) begin
          rsp_p_d     = mul_p;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_p_q     <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_p_q     <= rsp_p_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_p     = rsp_p_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_valid = rsp_valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_lookup_mult_arbiter.sv
module tb_lookup_mult_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Three instances: multiplier latency 0, 2 and 3.
  logic        rst_n     [3];
  logic [3:0]  req_valid [3];
  logic [31:0] req_a     [3];
  logic [31:0] req_b     [3];
  logic [3:0]  req_ready [3];
  logic [7:0]  mul_a     [3];
  logic [7:0]  mul_b     [3];
  logic [15:0] mul_p     [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [15:0] rsp_p     [3];
  logic [1:0]  rsp_id    [3];
  logic        busy      [3];

  int n_cmp = 0;
  int n_bad = 0;
  int mptr [3];

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int LAT = (g == 0) ? 0 : ((g == 1) ? 2 : 3);

    lookup_mult_arbiter #(
      .NUM_REQ(4), .ID_WIDTH(2), .MUL_LATENCY(LAT)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_a     (req_a[g]),
      .req_b     (req_b[g]),
      .req_ready (req_ready[g]),
      .mul_a     (mul_a[g]),
      .mul_b     (mul_b[g]),
      .mul_p     (mul_p[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_p     (rsp_p[g]),
      .rsp_id    (rsp_id[g]),
      .busy      (busy[g])
    );

    // External multiplier model: combinational, or a LAT-deep pipeline.
    if (LAT == 0) begin : g_comb
      assign mul_p[g] = 16'(mul_a[g]) * 16'(mul_b[g]);
    end else begin : g_pipe
      logic [15:0] pipe [LAT];
      always @(posedge clk) begin
        pipe[0] <= 16'(mul_a[g]) * 16'(mul_b[g]);
        for (int j = 1; j < LAT; j++) pipe[j] <= pipe[j-1];
      end
      assign mul_p[g] = pipe[LAT-1];
    end
  end

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : ((k == 1) ? 2 : 3);
  endfunction

  // Reference arbitration: first valid requester scanning from ptr.
  function automatic int pick(input int p, input logic [3:0] v);
    for (int j = 0; j < 4; j++) begin
      if (v[(p + j) % 4]) return (p + j) % 4;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s (dut%0d): observed %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  // One complete transaction on instance k, starting in IDLE a cycle
  // boundary + 1 time unit. The winner drops valid once granted.
  task automatic txn(input int k, input logic [3:0] vld, input int stall);
    int w, ea, eb;
    req_valid[k] = vld;
    #1;
    w = pick(mptr[k], vld);
    if (w < 0) begin
      chk("idle_ready", k, 32'(req_ready[k]), 0);
      @(posedge clk); #1;
      chk("idle_busy", k, 32'(busy[k]), 0);
      chk("idle_rsp_valid", k, 32'(rsp_valid[k]), 0);
      return;
    end
    ea = int'(req_a[k][8*w +: 8]);
    eb = int'(req_b[k][8*w +: 8]);
    chk("grant", k, 32'(req_ready[k]), 32'(1) << w);
    chk("idle_busy", k, 32'(busy[k]), 0);
    @(posedge clk); #1;
    mptr[k] = (w + 1) % 4;
    req_valid[k][w] = 1'b0;
    req_a[k][8*w +: 8] = 8'($urandom);
    req_b[k][8*w +: 8] = 8'($urandom);
    for (int i = 0; i <= lat_of(k); i++) begin
      chk("exec_busy", k, 32'(busy[k]), 1);
      chk("exec_rsp_valid", k, 32'(rsp_valid[k]), 0);
      chk("exec_ready", k, 32'(req_ready[k]), 0);
      chk("exec_mul_a", k, 32'(mul_a[k]), ea);
      chk("exec_mul_b", k, 32'(mul_b[k]), eb);
      @(posedge clk); #1;
    end
    chk("rsp_valid", k, 32'(rsp_valid[k]), 1);
    chk("rsp_p", k, 32'(rsp_p[k]), ea * eb);
    chk("rsp_id", k, 32'(rsp_id[k]), w);
    chk("rsp_busy", k, 32'(busy[k]), 1);
    chk("rsp_ready_out", k, 32'(req_ready[k]), 0);
    if (stall > 0) begin
      rsp_ready[k] = 1'b0;
      for (int s = 0; s < stall; s++) begin
        @(posedge clk); #1;
        chk("stall_valid", k, 32'(rsp_valid[k]), 1);
        chk("stall_p", k, 32'(rsp_p[k]), ea * eb);
        chk("stall_id", k, 32'(rsp_id[k]), w);
        chk("stall_ready_out", k, 32'(req_ready[k]), 0);
        chk("stall_busy", k, 32'(busy[k]), 1);
      end
      rsp_ready[k] = 1'b1;
    end
    @(posedge clk); #1;
    chk("done_valid", k, 32'(rsp_valid[k]), 0);
    chk("done_busy", k, 32'(busy[k]), 0);
    chk("hold_mul_a", k, 32'(mul_a[k]), ea);
  endtask

  task automatic chk_zero(input int k);
    chk("rst_busy", k, 32'(busy[k]), 0);
    chk("rst_rsp_valid", k, 32'(rsp_valid[k]), 0);
    chk("rst_ready", k, 32'(req_ready[k]), 0);
    chk("rst_mul_a", k, 32'(mul_a[k]), 0);
    chk("rst_mul_b", k, 32'(mul_b[k]), 0);
    chk("rst_rsp_p", k, 32'(rsp_p[k]), 0);
    chk("rst_rsp_id", k, 32'(rsp_id[k]), 0);
  endtask

  initial begin
    int prods [4];
    logic [3:0] v;
    prods = '{15, 77, 0, 256};

    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0;
      req_valid[k] = '0;
      req_a[k] = '0;
      req_b[k] = '0;
      rsp_ready[k] = 1'b1;
      mptr[k] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk_zero(k);
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(posedge clk); #1;

    // ---- latency 0 ----
    req_a[0] = 32'd200;
    req_b[0] = 32'd255;
    txn(0, 4'b0001, 0);
    chk("c738", 0, 32'(rsp_p[0]), 32'h0000C738);

    // Bring ptr to 0, then all four valid.
    req_a[0] = $urandom;
    req_b[0] = $urandom;
    txn(0, 4'b1000, 0);
    req_a[0] = {8'd16, 8'd0, 8'd7, 8'd3};
    req_b[0] = {8'd16, 8'd99, 8'd11, 8'd5};
    req_valid[0] = 4'hF;
    for (int i = 0; i < 4; i++) begin
      txn(0, req_valid[0], 0);
      chk("order_id", 0, 32'(rsp_id[0]), i);
      chk("order_p", 0, 32'(rsp_p[0]), prods[i]);
    end
    req_a[0] = $urandom;
    req_b[0] = $urandom;
    txn(0, 4'hF, 0);
    chk("wrap_id", 0, 32'(rsp_id[0]), 0);

    // ptr -> 2, then requesters 1 and 3.
    txn(0, 4'b0010, 0);
    txn(0, 4'b1010, 0);
    chk("skip_id3", 0, 32'(rsp_id[0]), 3);
    req_valid[0][3] = 1'b1;
    txn(0, req_valid[0], 0);
    chk("skip_id1", 0, 32'(rsp_id[0]), 1);
    txn(0, req_valid[0], 0);
    chk("skip_id3b", 0, 32'(rsp_id[0]), 3);

    // Backpressure with another requester waiting.
    req_a[0] = $urandom;
    req_b[0] = $urandom;
    txn(0, 4'b0101, 5);
    txn(0, req_valid[0], 0);
    chk("bp_next_id", 0, 32'(rsp_id[0]), 2);

    for (int it = 0; it < 15; it++) begin
      req_a[0] = $urandom;
      req_b[0] = $urandom;
      v = 4'($urandom_range(0, 15));
      txn(0, v, $urandom_range(0, 2));
    end

    // ---- latency 2 ----
    req_a[1] = 32'h00FF0000;
    req_b[1] = 32'h00FF0000;
    txn(1, 4'b0100, 0);
    chk("fe01", 1, 32'(rsp_p[1]), 32'h0000FE01);
    chk("fe01_id", 1, 32'(rsp_id[1]), 2);
    for (int it = 0; it < 8; it++) begin
      req_a[1] = $urandom;
      req_b[1] = $urandom;
      v = 4'($urandom_range(1, 15));
      txn(1, v, $urandom_range(0, 3));
    end

    // ---- latency 3: reset mid-EXEC ----
    req_a[2] = 32'h5A000000;
    req_b[2] = 32'h3C000000;
    txn(2, 4'b1000, 0);
    req_a[2] = 32'h00A50000;
    req_b[2] = 32'h00C30000;
    req_valid[2] = 4'b0100;
    #1;
    chk("pre_rst_grant", 2, 32'(req_ready[2]), 32'h4);
    @(posedge clk); #1;
    req_valid[2] = 4'b0000;
    chk("pre_rst_busy", 2, 32'(busy[2]), 1);
    @(posedge clk); #1;
    rst_n[2] = 1'b0;
    #1;
    chk_zero(2);
    @(posedge clk); #1;
    rst_n[2] = 1'b1;
    mptr[2] = 0;
    for (int c = 0; c < 6; c++) begin
      chk("post_rst_valid", 2, 32'(rsp_valid[2]), 0);
      chk("post_rst_busy", 2, 32'(busy[2]), 0);
      @(posedge clk); #1;
    end
    req_a[2] = $urandom;
    req_b[2] = $urandom;
    txn(2, 4'b1010, 0);
    chk("post_rst_id", 2, 32'(rsp_id[2]), 1);
    txn(2, req_valid[2], 1);
    chk("post_rst_id3", 2, 32'(rsp_id[2]), 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/lookup_mult_arbiter.md
Name: lookup_mult_arbiter

Overview:
- Shares one 8x8 quarter-square lookup multiplier (adder/subtractor + two 512x16 ROMs + final 16-bit subtract) between NUM_REQ requesters.
- Round-robin arbitration, valid/ready request handshake per requester, one operation in flight, result returned with requester ID over a valid/ready response channel.
- Sits between the requesting engines and the multiplier. The multiplier stays a separate instance; its operand and product ports connect here.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of rsp_id; must satisfy 2**ID_WIDTH >= NUM_REQ.
- MUL_LATENCY, 0, cycles from operands stable on mul_a/mul_b to a valid mul_p (0..7). Use 0 for the combinational multiplier and 1 when the ROM outputs are registered.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  request valid, one bit per requester.
- req_a  in  8*NUM_REQ  multiplicand; requester i uses bits [8i+7:8i].
- req_b  in  8*NUM_REQ  multiplier operand, same packing as req_a.
- req_ready  out  NUM_REQ  grant/accept, one-hot or zero.
- mul_a  out  8  operand A to the shared multiplier.
- mul_b  out  8  operand B to the shared multiplier.
- mul_p  in  16  product from the shared multiplier.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted by the consumer.
- rsp_p  out  16  unsigned product a*b.
- rsp_id  out  ID_WIDTH  index of the requester that owns rsp_p.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release) forces the following:
  - state = IDLE, ptr = 0, cnt = 0.
  - mul_a = mul_b = 0, rsp_p = 0, rsp_id = 0.
  - rsp_valid = 0, req_ready = 0, busy = 0.
- The FSM has three states:
  - IDLE:
    - Winner is the first i with req_valid[i]=1, scanning ptr, ptr+1, ... and wrapping modulo NUM_REQ.
    - req_ready[winner] = 1 combinationally in the same cycle. All other req_ready bits are 0.
    - On that edge: latch req_a/req_b slices into mul_a/mul_b, latch winner into rsp_id, set cnt = MUL_LATENCY, set ptr = (winner+1) mod NUM_REQ, go to EXEC.
    - If no req_valid bit is set: stay in IDLE, ptr unchanged.
  - EXEC:
    - If cnt==0: rsp_p <= mul_p, go to RESP.
    - Else cnt <= cnt-1.
    - mul_a/mul_b hold their values for the whole of EXEC.
  - RESP:
    - rsp_valid = 1. rsp_p and rsp_id hold stable.
    - When rsp_ready=1: go to IDLE. rsp_valid drops the next cycle.
    - No new grant is issued in the RESP cycle.
- req_ready is 0 outside IDLE.
- Requesters hold valid and operands until they see ready. Dropping valid before a grant is legal; that requester is simply skipped.
- Latency:
  - Grant edge G puts operands on mul_a/mul_b in cycle G+1.
  - mul_p is sampled at the end of cycle G+1+MUL_LATENCY.
  - rsp_valid rises in cycle G+2+MUL_LATENCY.
  - Back-to-back peak throughput is one result per 3+MUL_LATENCY cycles, with rsp_ready held high.
- rsp_p width is 16 bits with no truncation, since 255*255 = 0xFE01 fits. The block does no arithmetic of its own; rsp_p is mul_p verbatim.
- mul_a/mul_b keep their last values after RESP until the next grant. There is no glitching back to 0.
- Boundary cases:
  - Only the ptr requester valid: it is granted.
  - Winner at NUM_REQ-1: ptr wraps to 0.
  - All requesters valid continuously: grant order is strictly 0,1,2,...,NUM_REQ-1,0,...
  - rsp_ready held low indefinitely: the block stays in RESP with rsp_valid, rsp_p and rsp_id stable, and grants nothing.
  - rsp_ready high while rsp_valid is 0: ignored.
  - rst_n asserted in EXEC or RESP: the in-flight operation is discarded, no response is produced, and state returns to IDLE with ptr=0.

Test Plan:
- MUL_LATENCY=0: req 0 with a=200, b=255 -> req_ready[0] pulses one cycle. rsp_valid appears 2 cycles after grant with rsp_p=0xC738 and rsp_id=0.
- MUL_LATENCY=2, registered multiplier model: a=255, b=255 on req 2 -> rsp_p=0xFE01, rsp_id=2, rsp_valid 4 cycles after grant. mul_a/mul_b stay stable through EXEC.
- All 4 requesters valid with distinct operands (3*5, 7*11, 0*99, 16*16) and rsp_ready=1 -> responses in ID order 0,1,2,3 with products 15, 77, 0, 256. The next grant goes to 0.
- Requesters 1 and 3 valid, ptr=2 -> 3 granted first, then 1. Requester 3 re-raises valid -> 1 is granted before 3 again.
- Backpressure: rsp_ready low for 5 cycles during RESP -> rsp_valid, rsp_p and rsp_id stay constant, req_ready stays 0, and busy=1 until the handshake completes.
- Reset pulse mid-EXEC (MUL_LATENCY=3) -> all outputs 0 immediately and no rsp_valid after release. The next request from requester 1 is granted with ptr restarting at 0.
